pipe_scoreboard: RTL
====================

Name: pipe_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order pipelined MIPS datapath.
- Replaces the fixed load-use hazard check and the two-source forwarding unit with a per-register scoreboard.
- Tracks in-flight register writes of variable producer latency (ALU, load, multi-cycle units) and drives stall and forwarding-source selects for the instruction in ID.
- Supports arbitrary write-back distance and register-file size.

Parameters:
- REG_ADDR_W, 5, register address width; the register file holds 2**REG_ADDR_W registers and register 0 is hardwired zero.
- WB_DIST, 3, cycles from issue (leaving ID) to register-file write; a forwarding source exists for each age 1..WB_DIST-1.
- AGE_W, 2, width of the age counters and forward selects; must satisfy 2**AGE_W > WB_DIST.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  valid instruction present in ID
- id_flush  in  1  ID instruction squashed (taken branch/jump); it must not issue
- id_rs  in  REG_ADDR_W  first source register
- id_rt  in  REG_ADDR_W  second source register
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_wr_en  in  1  instruction writes a register
- id_wd  in  REG_ADDR_W  destination register
- id_lat  in  AGE_W  producer latency: cycles after issue until the result can be forwarded
- stall  out  1  hold PC and IF/ID, inject bubble into ID/EX
- fwd_a  out  AGE_W  rs source: 0 = register file, k = stage holding a result of age k
- fwd_b  out  AGE_W  rt source, same encoding as fwd_a
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- State per register r≠0: pending[r], age[r] (AGE_W bits), lat[r] (AGE_W bits).
- Reset (async, immediate): all pending=0, all age=0, all lat=0, stall_cnt=0. Consequently stall=0, fwd_a=0 and fwd_b=0 while rst is high.
- Issue condition: `issue = id_valid & ~id_flush & ~stall`.
- On a clock edge with issue & id_wr_en & id_wd≠0:
  - pending[id_wd] is set to 1.
  - age[id_wd] is set to 1.
  - lat[id_wd] takes the clamped id_lat.
  - Clamping: id_lat=0 is treated as 1; values above WB_DIST are treated as WB_DIST.
- Every edge, for each pending register not being re-issued:
  - age increments.
  - When age reaches WB_DIST it is the register-file write cycle; on the following edge pending clears.
- Same-destination reissue: the newest writer overwrites the entry (age=1, new lat). Older in-flight writers to that register are no longer tracked; the newest value is the architecturally correct one.
- Combinational source check for source s (rs or rt), valid only when its use flag is set and s≠0:
  - Not pending: fwd=0, no hazard.
  - pending & age ≥ lat: fwd=age when age<WB_DIST; fwd=0 when age=WB_DIST (register-file write-through); no hazard.
  - pending & age < lat: hazard, fwd=0.
- Unused or zero source: fwd=0 and no hazard.
- stall = id_valid & ~id_flush & (hazard_rs | hazard_rt). Flush has priority over stall.
- Reads use pre-edge state. An instruction whose destination equals one of its own sources checks against the older writer.
- During stall, no state is written for the ID instruction and ages of pending entries keep advancing. The stall therefore resolves after exactly lat−age cycles.
- stall_cnt increments on each edge where stall=1 and saturates at all-ones.
- Reset asserted mid-operation clears all tracking immediately. The first instruction after reset sees no pending registers.

Test Plan:
- Reset: assert rst for 2 cycles, release, issue `add $3` (lat 1) → stall=0, fwd_a=0, stall_cnt=0, no pending before the issue edge.
- ALU back-to-back: `add $3` (lat 1) then `sub $4,$3,$5` next cycle → no stall, fwd_a=1, fwd_b=0; one cycle later a reader of $3 gets fwd=2; at age 3 it gets fwd=0.
- Load-use: `lw $2` (lat 2) then `add $6,$2,$2` → stall=1 for exactly 1 cycle, stall_cnt=1, then fwd_a=fwd_b=2.
- Multi-cycle: WB_DIST=5, AGE_W=3, `mul $7` with lat 4, immediate consumer of $7 → stall for 3 cycles, then fwd=4.
- Flush vs hazard: load `$2`, then the next ID instruction reads $2 with id_flush=1 → stall=0, no issue, $2 age still advances; writes to $0 never become pending.
- Overwrite and saturation: `lw $2` then `add $2` (lat 1) → a reader of $2 gets fwd=1 with no stall. Force stall_cnt to its maximum with CNT_W=2 and continuous stalls → stall_cnt holds at 3.

Source files
------------

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: per-register scoreboard driving ID stall and forwarding selects
module pipe_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int WB_DIST    = 3,
  parameter int AGE_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_flush,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wd,
  input  logic [AGE_W-1:0]      id_lat,
  output logic                  stall,
  output logic [AGE_W-1:0]      fwd_a,
  output logic [AGE_W-1:0]      fwd_b,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam int NR = 1 << REG_ADDR_W;
  localparam logic [AGE_W-1:0] WB = AGE_W'(WB_DIST);

  logic [NR-1:0]            pend_q, pend_d, set;
  logic [NR-1:0][AGE_W-1:0] age_q, age_d, lat_q, lat_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [AGE_W-1:0]         lat_c, age_a, age_b;
  logic                     pnd_a, pnd_b, haz_a, haz_b, issue;

  assign age_a = age_q[id_rs];
  assign age_b = age_q[id_rt];
  assign pnd_a = id_use_rs && id_rs != '0 && pend_q[id_rs];
  assign pnd_b = id_use_rt && id_rt != '0 && pend_q[id_rt];
  assign haz_a = pnd_a && age_a < lat_q[id_rs];
  assign haz_b = pnd_b && age_b < lat_q[id_rt];
  assign fwd_a = (pnd_a && !haz_a && age_a != WB) ? age_a : '0;
  assign fwd_b = (pnd_b && !haz_b && age_b != WB) ? age_b : '0;
  assign stall = id_valid && !id_flush && (haz_a || haz_b);
  assign issue = id_valid && !id_flush && !stall;
  assign lat_c = id_lat == '0 ? AGE_W'(1) : (id_lat > WB ? WB : id_lat);
  assign set   = {{(NR-1){1'b0}}, issue && id_wr_en && id_wd != '0} << id_wd;
  assign stall_cnt = cnt_q;

  // next scoreboard state: new writer claims its entry, others age and retire after the write cycle
  always_comb begin
    pend_d = pend_q;
    age_d  = age_q;
    lat_d  = lat_q;
    cnt_d  = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    for (int r = 1; r < NR; r++) begin
      if (set[r]) begin
        pend_d[r] = 1'b1;
        age_d[r]  = AGE_W'(1);
        lat_d[r]  = lat_c;
      end else if (pend_q[r]) begin
        pend_d[r] = age_q[r] != WB;
        age_d[r]  = age_q[r] == WB ? '0 : age_q[r] + 1'b1;
      end
    end
  end

  // scoreboard and statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      age_q  <= '0;
      lat_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      age_q  <= age_d;
      lat_q  <= lat_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule
